// File: rtl/mdll_jm_ctrl.sv
// MDLL jitter-measurement controller: waits for mtune to settle, then runs
// nmeas timed en_jm windows and hands each captured jm_out to a consumer.
module mdll_jm_ctrl (
    input  logic        clk,
    input  logic        rstb,
    input  logic        start,
    input  logic [5:0]  ncycle_cfg,
    input  logic [3:0]  nmeas_cfg,
    input  logic [3:0]  lock_win,
    input  logic [7:0]  lock_cnt_cfg,
    input  logic [12:0] lf_out,
    input  logic [19:0] jm_out,
    input  logic        result_ready,
    output logic        en_jm,
    output logic [5:0]  ncycle_jm,
    output logic        locked,
    output logic        busy,
    output logic        result_valid,
    output logic [19:0] result,
    output logic [3:0]  meas_idx,
    output logic        err_timeout,
    output logic        lock_lost
);

    typedef enum logic [2:0] {
        IDLE, LOCK_WAIT, MEAS, SETTLE, CAPTURE, HOLD, ERR
    } state_t;

    state_t      state;
    logic [6:0]  mtune;
    logic [6:0]  ref_mtune;
    logic [7:0]  dev;
    logic [7:0]  run_cnt;
    logic [7:0]  meas_cnt;
    logic [15:0] to_cnt;
    logic [3:0]  nmeas_q;
    logic        settle_cnt;
    logic        in_win;
    logic        lose;
    logic        unused_lf;

    assign mtune     = lf_out[12:6];
    assign unused_lf = ^lf_out[5:0];

    // Deviation is taken in 8 bits so the full 0..127 span never wraps.
    always_comb begin
        dev = 8'd0;
        if ({1'b0, mtune} >= {1'b0, ref_mtune}) begin
            dev = {1'b0, mtune} - {1'b0, ref_mtune};
        end else begin
            dev = {1'b0, ref_mtune} - {1'b0, mtune};
        end
        in_win = (dev <= {4'b0000, lock_win});
        lose   = ((state == MEAS) || (state == SETTLE) || (state == HOLD)) && !in_win;
    end

    // Handshake: result is offered while result_valid=1 and is consumed on the
    // cycle where result_valid and result_ready are both high.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state        <= IDLE;
            en_jm        <= 1'b0;
            ncycle_jm    <= 6'd0;
            locked       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 20'd0;
            meas_idx     <= 4'd0;
            err_timeout  <= 1'b0;
            lock_lost    <= 1'b0;
            ref_mtune    <= 7'd0;
            run_cnt      <= 8'd0;
            meas_cnt     <= 8'd0;
            to_cnt       <= 16'd0;
            nmeas_q      <= 4'd0;
            settle_cnt   <= 1'b0;
        end else if (lose) begin
            // Lock loss wins over a same-cycle handshake; that result is dropped.
            state        <= LOCK_WAIT;
            lock_lost    <= 1'b1;
            locked       <= 1'b0;
            en_jm        <= 1'b0;
            result_valid <= 1'b0;
            run_cnt      <= 8'd0;
            to_cnt       <= 16'd0;
            ref_mtune    <= mtune;
        end else begin
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        ncycle_jm   <= ncycle_cfg;
                        nmeas_q     <= nmeas_cfg;
                        err_timeout <= 1'b0;
                        lock_lost   <= 1'b0;
                        meas_idx    <= 4'd0;
                        ref_mtune   <= mtune;
                        run_cnt     <= 8'd0;
                        to_cnt      <= 16'd0;
                        busy        <= 1'b1;
                        state       <= LOCK_WAIT;
                    end
                end
                LOCK_WAIT: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (in_win) begin
                        if (run_cnt != 8'hFF) begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end else begin
                        run_cnt   <= 8'd0;
                        ref_mtune <= mtune;
                    end
                    if (in_win && (run_cnt == lock_cnt_cfg)) begin
                        state    <= MEAS;
                        locked   <= 1'b1;
                        en_jm    <= 1'b1;
                        meas_cnt <= 8'd0;
                    end else if (to_cnt == 16'hFFFE) begin
                        // This edge makes the counter reach 65535.
                        state       <= ERR;
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        en_jm       <= 1'b0;
                    end
                end
                MEAS: begin
                    if (meas_cnt == {ncycle_jm, 2'b11}) begin
                        en_jm      <= 1'b0;
                        settle_cnt <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        meas_cnt <= meas_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end
                CAPTURE: begin
                    result       <= jm_out;
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        // nmeas_q of 0 wraps to 15 here, i.e. 16 measurements.
                        if (meas_idx == (nmeas_q - 4'd1)) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            locked <= 1'b0;
                        end else begin
                            meas_idx <= meas_idx + 4'd1;
                            en_jm    <= 1'b1;
                            meas_cnt <= 8'd0;
                            state    <= MEAS;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    en_jm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdll_jm_ctrl.sv
// Directed bench for mdll_jm_ctrl: result scoreboard plus timing checks on
// lock, en_jm window length, backpressure, lock loss, reset and timeout.
module tb_mdll_jm_ctrl;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  ncycle_cfg = 6'd3;
  logic [3:0]  nmeas_cfg = 4'd1;
  logic [3:0]  lock_win = 4'd1;
  logic [7:0]  lock_cnt_cfg = 8'd10;
  logic [12:0] lf_out = 13'd0;
  logic [19:0] jm_out = 20'd0;
  logic        result_ready = 1'b1;
  logic        en_jm;
  logic [5:0]  ncycle_jm;
  logic        locked;
  logic        busy;
  logic        result_valid;
  logic [19:0] result;
  logic [3:0]  meas_idx;
  logic        err_timeout;
  logic        lock_lost;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] sb_exp;
  logic [23:0] sb_got;

  int run_len = 0;
  int last_len = 0;
  int pulses = 0;
  int rv_cycles = 0;

  mdll_jm_ctrl dut (
    .clk(clk), .rstb(rstb), .start(start), .ncycle_cfg(ncycle_cfg),
    .nmeas_cfg(nmeas_cfg), .lock_win(lock_win), .lock_cnt_cfg(lock_cnt_cfg),
    .lf_out(lf_out), .jm_out(jm_out), .result_ready(result_ready),
    .en_jm(en_jm), .ncycle_jm(ncycle_jm), .locked(locked), .busy(busy),
    .result_valid(result_valid), .result(result), .meas_idx(meas_idx),
    .err_timeout(err_timeout), .lock_lost(lock_lost)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard monitor: pops one expected {meas_idx, result} per handshake
  always @(negedge clk) begin
    if (rstb && result_valid && result_ready) begin
      checks++;
      sb_got = {meas_idx, result};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got idx %0d result %05h, expected no result", meas_idx, result);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          errors++;
          $display("FAIL sb_result: got idx %0d result %05h, expected idx %0d result %05h",
                   sb_got[23:20], sb_got[19:0], sb_exp[23:20], sb_exp[19:0]);
        end
      end
    end
  end

  // en_jm pulse and result_valid activity monitor
  always @(negedge clk) begin
    if (result_valid) rv_cycles++;
    if (en_jm) begin
      run_len++;
    end else if (run_len > 0) begin
      last_len = run_len;
      pulses++;
      run_len = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mtune(input logic [6:0] v);
    lf_out = {v, 6'($urandom_range(0, 63))};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_locked(input string name, output int n);
    n = 0;
    while (!locked && n < 300) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (!en_jm && n < 300) begin
      step(1);
      n++;
    end
    if (!en_jm) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 6000) begin
      step(1);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en_jm"}, {31'd0, en_jm}, 32'd0);
    check({tag, "_ncycle_jm"}, {26'd0, ncycle_jm}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_result"}, {12'd0, result}, 32'd0);
    check({tag, "_meas_idx"}, {28'd0, meas_idx}, 32'd0);
    check({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
    check({tag, "_lock_lost"}, {31'd0, lock_lost}, 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    int rv0;
    int stable;

    // reset state
    set_mtune(7'd40);
    step(3);
    check_reset_values("reset");
    rstb = 1'b1;
    step(1);

    // basic run
    ncycle_cfg = 6'd3; nmeas_cfg = 4'd1; lock_win = 4'd1; lock_cnt_cfg = 8'd10;
    jm_out = 20'h00ABC; result_ready = 1'b1;
    p0 = pulses; rv0 = rv_cycles;
    exp_q.push_back({4'd0, 20'h00ABC});
    pulse_start();
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_ncycle_jm", {26'd0, ncycle_jm}, 32'd3);
    wait_locked("basic_lock", n);
    check("basic_lock_latency", n, 32'd11);
    wait_idle("basic_idle");
    check("basic_pulses", pulses - p0, 32'd1);
    check("basic_en_len", last_len, 32'd16);
    check("basic_rv_cycles", rv_cycles - rv0, 32'd1);
    check("basic_locked_after", {31'd0, locked}, 32'd0);

    // backpressure
    nmeas_cfg = 4'd2; result_ready = 1'b0; jm_out = 20'h12345;
    p0 = pulses;
    exp_q.push_back({4'd0, 20'h12345});
    pulse_start();
    n = 0;
    while (!result_valid && n < 300) begin
      step(1);
      n++;
    end
    check("bp_valid_rise", {31'd0, result_valid}, 32'd1);
    jm_out = 20'h0BEEF;
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (result_valid && result == 20'h12345 && !en_jm) stable++;
    end
    check("bp_stable_cycles", stable, 32'd50);
    check("bp_one_pulse", pulses - p0, 32'd1);
    exp_q.push_back({4'd1, 20'h0BEEF});
    result_ready = 1'b1;
    step(2);
    check("bp_meas_idx", {28'd0, meas_idx}, 32'd1);
    wait_idle("bp_idle");
    check("bp_pulses", pulses - p0, 32'd2);
    check("bp_en_len", last_len, 32'd16);

    // lock loss mid-MEAS
    nmeas_cfg = 4'd1; lock_win = 4'd2; jm_out = 20'h00777;
    exp_q.push_back({4'd0, 20'h00777});
    pulse_start();
    wait_en("ll_en_start");
    step(5);
    set_mtune(7'd45);
    step(1);
    check("ll_en_drop", {31'd0, en_jm}, 32'd0);
    check("ll_lock_lost", {31'd0, lock_lost}, 32'd1);
    check("ll_locked", {31'd0, locked}, 32'd0);
    check("ll_busy", {31'd0, busy}, 32'd1);
    wait_locked("ll_relock", n);
    check("ll_relock_latency", n, 32'd11);
    check("ll_meas_idx", {28'd0, meas_idx}, 32'd0);
    wait_idle("ll_idle");
    check("ll_sticky", {31'd0, lock_lost}, 32'd1);

    // boundary: 16 measurements, minimum window, immediate lock
    set_mtune(7'd40);
    nmeas_cfg = 4'd0; ncycle_cfg = 6'd0; lock_cnt_cfg = 8'd0; jm_out = 20'hF0F0F;
    p0 = pulses; rv0 = rv_cycles;
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 20'hF0F0F});
    pulse_start();
    wait_locked("b16_lock", n);
    check("b16_lock_latency", n, 32'd1);
    wait_idle("b16_idle");
    check("b16_pulses", pulses - p0, 32'd16);
    check("b16_en_len", last_len, 32'd4);
    check("b16_rv_cycles", rv_cycles - rv0, 32'd16);

    // boundary: longest window
    nmeas_cfg = 4'd1; ncycle_cfg = 6'd63; lock_cnt_cfg = 8'd10; jm_out = 20'hFFFFF;
    exp_q.push_back({4'd0, 20'hFFFFF});
    pulse_start();
    check("b63_ncycle_jm", {26'd0, ncycle_jm}, 32'd63);
    wait_idle("b63_idle");
    check("b63_en_len", last_len, 32'd256);

    // reset mid-MEAS, with sticky lock_lost set first
    ncycle_cfg = 6'd5; jm_out = 20'h00123;
    pulse_start();
    wait_en("rst_en_first");
    step(2);
    set_mtune(7'd45);
    step(1);
    check("rst_pre_lock_lost", {31'd0, lock_lost}, 32'd1);
    wait_en("rst_en_second");
    step(3);
    rstb = 1'b0;
    start = 1'b1;
    step(1);
    rstb = 1'b1;
    start = 1'b0;
    check_reset_values("midrst");
    step(1);
    check("midrst_start_ignored", {31'd0, busy}, 32'd0);

    // timeout: mtune alternates 0/127 every cycle
    lock_win = 4'd1;
    set_mtune(7'd0);
    pulse_start();
    n = 0;
    while (!err_timeout && n < 70000) begin
      set_mtune(lf_out[12:6] == 7'd0 ? 7'd127 : 7'd0);
      step(1);
      n++;
    end
    check("to_latency", n, 32'd65535);
    check("to_busy", {31'd0, busy}, 32'd1);
    check("to_en_jm", {31'd0, en_jm}, 32'd0);
    check("to_locked", {31'd0, locked}, 32'd0);
    set_mtune(7'd40);
    step(3);
    check("to_err_hold", {31'd0, err_timeout}, 32'd1);
    jm_out = 20'h0CAFE;
    exp_q.push_back({4'd0, 20'h0CAFE});
    pulse_start();
    check("to_recover_clear", {31'd0, err_timeout}, 32'd0);
    check("to_recover_busy", {31'd0, busy}, 32'd1);
    wait_idle("to_recover_idle");

    step(2);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
